// File: rtl/piso.sv
// piso: parallel-in serial-out width converter.
// A wide word accepted on the input handshake is emitted as NUM_SHIFTS narrow
// slices, least-significant slice first. A one-word pending buffer lets the
// next word be accepted while the current one drains, so consecutive words
// stream without a bubble.
// Optional feature macro: PISO_LAST_EN adds out_last (final slice marker) and
// in_flush (discard everything and return to idle).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | shifter empty, out_valid low
// S_SHIFT | shifter holds a word, out_valid high, data_out = low slice
module piso #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      busy
`ifdef PISO_LAST_EN
    ,
    input  logic                      in_flush,
    output logic                      out_last
`endif
);

    localparam int NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CNT_W      = $clog2(NUM_SHIFTS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SHIFTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DATA_IN_WIDTH % DATA_OUT_WIDTH != 0) begin : g_width_check
        $error("piso: DATA_IN_WIDTH must be a multiple of DATA_OUT_WIDTH");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                     r_state;
    logic [DATA_IN_WIDTH-1:0]   r_shift;
    logic [DATA_IN_WIDTH-1:0]   r_pend;
    logic                       r_pend_v;
    logic [CNT_W-1:0]           r_cnt;

    logic w_accept;
    logic w_beat;
    logic w_last_beat;
    logic w_flush;

    // in_ready depends only on registered state, so there is no path from out_ready
    assign in_ready    = !r_pend_v;
    assign w_accept    = in_valid && !r_pend_v;
    assign w_beat      = (r_state == S_SHIFT) && out_ready;
    assign w_last_beat = w_beat && (r_cnt == CNT_ONE);

    assign out_valid = (r_state == S_SHIFT);
    assign data_out  = r_shift[DATA_OUT_WIDTH-1:0];
    assign busy      = (r_state == S_SHIFT) || r_pend_v;

`ifdef PISO_LAST_EN
    assign w_flush  = in_flush;
    assign out_last = (r_state == S_SHIFT) && (r_cnt == CNT_ONE);
`else
    assign w_flush  = 1'b0;
`endif

    // Shifter / pending-buffer FSM; a flush or reset drops every partial word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_cnt    <= '0;
        end else if (w_flush) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= data_in;
                        r_cnt   <= CNT_FULL;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_last_beat) begin
                        if (r_pend_v) begin
                            r_shift  <= r_pend;
                            r_pend   <= '0;
                            r_pend_v <= 1'b0;
                            r_cnt    <= CNT_FULL;
                        end else if (w_accept) begin
                            // pending buffer is empty: bypass it straight into the shifter
                            r_shift <= data_in;
                            r_cnt   <= CNT_FULL;
                        end else begin
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (w_beat) begin
                            r_shift <= r_shift >> DATA_OUT_WIDTH;
                            r_cnt   <= r_cnt - CNT_ONE;
                        end
                        if (w_accept) begin
                            r_pend   <= data_in;
                            r_pend_v <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso.sv
// tb_piso: self-checking bench for piso (64->16 instance plus a 16->16 instance).
// The reference model treats each DUT as a two-word FIFO of accepted words and
// emits the front word's slices in LSB-first order.
module tb_piso;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] data_in;
    logic [15:0] data_out;
`ifdef PISO_LAST_EN
    logic        in_flush, out_last;
    logic        e_in_flush, e_out_last;
`endif

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_busy;
    logic [15:0] e_data_in, e_data_out;

    piso #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .busy(busy)
`ifdef PISO_LAST_EN
        , .in_flush(in_flush), .out_last(out_last)
`endif
    );

    piso #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) u_eq (
        .clk(clk), .reset(reset),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .data_in(e_data_in),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .data_out(e_data_out),
        .busy(e_busy)
`ifdef PISO_LAST_EN
        , .in_flush(e_in_flush), .out_last(e_out_last)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // model state: words held by the DUT, and slice index within the front word
    logic [63:0] q[$];
    int          idx = 0;
    logic [15:0] eq_q[$];
    logic [15:0] eq_out[$];
    bit          eq_acc;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] slice_of(input logic [63:0] w, input int k);
        logic [63:0] t;
        t = w >> (16 * k);
        return t[15:0];
    endfunction

    // compare both DUTs against the model at the negedge, then advance the model
    task automatic sample();
        bit beat, acc, e_beat;
        @(negedge clk);
        eq_acc = 1'b0;
        if (!reset) begin
            q.delete();
            idx = 0;
            eq_q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_eq_out_valid", e_out_valid, 0);
            return;
        end
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("busy", busy, q.size() > 0);
        if (q.size() > 0) chk("data_out", data_out, slice_of(q[0], idx));
`ifdef PISO_LAST_EN
        chk("out_last", out_last, (q.size() > 0) && (idx == 3));
`endif
        beat = (q.size() > 0) && out_ready;
        acc  = in_valid && (q.size() < 2);
        if (beat) begin
            idx++;
            if (idx == 4) begin
                void'(q.pop_front());
                idx = 0;
            end
        end
        if (acc) q.push_back(data_in);

        chk("eq_out_valid", e_out_valid, eq_q.size() > 0);
        chk("eq_in_ready", e_in_ready, eq_q.size() < 2);
        chk("eq_busy", e_busy, eq_q.size() > 0);
        if (eq_q.size() > 0) chk("eq_data_out", e_data_out, eq_q[0]);
        e_beat = (eq_q.size() > 0) && e_out_ready;
        eq_acc = e_in_valid && (eq_q.size() < 2);
        if (e_beat) eq_out.push_back(eq_q.pop_front());
        if (eq_acc) eq_q.push_back(e_data_in);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] W2 = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] WA = 64'h8888_7777_6666_5555;
    localparam logic [63:0] WB = 64'hCCCC_BBBB_AAAA_9999;

    initial begin
        logic [15:0] t1 [4];
        int e_next;
        t1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b1; e_data_in = '0;
`ifdef PISO_LAST_EN
        in_flush = 1'b0; e_in_flush = 1'b0;
`endif
        #1;
        step();
        step();
        reset = 1'b1;
        sample();
        chk("post_reset_in_ready", in_ready, 1);
        advance();

        // single word, continuous out_ready
        in_valid = 1'b1; data_in = W1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("single_slice", data_out, t1[i]);
            advance();
        end
        sample();
        chk("single_done_valid", out_valid, 0);
        chk("single_done_busy", busy, 0);
        advance();

        // back-to-back words
        in_valid = 1'b1; data_in = WA;
        step();
        data_in = WB;
        step();
        in_valid = 1'b0;
        sample();
        chk("b2b_in_ready_low", in_ready, 0);
        advance();
        step();
        step();
        sample();
        chk("b2b_in_ready_high", in_ready, 1);
        chk("b2b_first_b", data_out, 16'h9999);
        advance();
        repeat (5) step();

        // backpressure after slice 2
        in_valid = 1'b1; data_in = W1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("bp_hold", data_out, 16'h2222);
            advance();
        end
        out_ready = 1'b1;
        sample();
        chk("bp_hold_last", data_out, 16'h2222);
        advance();
        sample();
        chk("bp_resume", data_out, 16'h3333);
        advance();
        repeat (3) step();

        // reset in the middle of a word
        in_valid = 1'b1; data_in = W1;
        step();
        in_valid = 1'b0;
        step();
        sample();
        chk("rst_mid_pre", data_out, 16'h2222);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_busy", busy, 0);
        advance();
        step();
        reset = 1'b1;
        in_valid = 1'b1; data_in = W2;
        step();
        in_valid = 1'b0;
        sample();
        chk("rst_new_first", data_out, 16'hAAAA);
        advance();
        repeat (4) step();

        // randomized traffic, with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 10) < 6;
            data_in   = {$urandom, $urandom};
            out_ready = ($urandom % 10) < 7;
            reset     = (n != 1500);
            step();
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) step();
        chk("rand_drain_empty", q.size() == 0, 1);
        step();

        // equal widths: skid-buffer behaviour
        eq_out.delete();
        e_next = 1;
        for (int n = 0; n < 200 && eq_out.size() < 5; n++) begin
            e_in_valid  = (e_next <= 5);
            e_data_in   = 16'(e_next);
            e_out_ready = $urandom_range(0, 1);
            sample();
            if (eq_acc) e_next++;
            advance();
        end
        e_in_valid = 1'b0;
        chk("eq_count", eq_out.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < eq_out.size()) chk("eq_seq", eq_out[i], i + 1);
        end
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in serial-out width converter; the transmit-side counterpart of the serial-in parallel-out converter.
- Accepts a wide word with a valid/ready handshake and emits it as a sequence of narrow slices, LSB slice first, under a valid/ready handshake.
- Slice order matches the receiver, so a piso feeding a sipo of the same widths reproduces the original word.
- Sits between wide on-chip buffers and narrow memory or stream interfaces.

Parameters:
DATA_IN_WIDTH, 64, width of the parallel input word; must be an integer multiple of DATA_OUT_WIDTH.
DATA_OUT_WIDTH, 16, width of each serial output slice.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
in_valid  input  1  input word valid.
in_ready  output  1  input word can be accepted this cycle.
data_in  input  DATA_IN_WIDTH  parallel word.
out_valid  output  1  data_out holds a valid slice.
out_ready  input  1  downstream accepts a slice this cycle.
data_out  output  DATA_OUT_WIDTH  current slice.
busy  output  1  shifter or pending buffer occupied.

Behaviour:
- Derived values:
  - NUM_SHIFTS = DATA_IN_WIDTH/DATA_OUT_WIDTH.
  - Beat counter width = clog2(NUM_SHIFTS)+1.
- Reset (reset=0, asynchronous):
  - shifter, pending buffer, counter and data_out go to 0.
  - out_valid=0, busy=0, in_ready=1 from the first cycle after reset is released.
  - Reset mid-word discards all partial state immediately; no slice of the discarded word is emitted afterwards.
- Storage: shift register SHIFT (DATA_IN_WIDTH), pending register PEND with flag pend_v, beat counter CNT (beats remaining).
- FSM states:
  - IDLE: SHIFT empty, out_valid=0.
  - SHIFT: out_valid=1, data_out=SHIFT[DATA_OUT_WIDTH-1:0].
- Handshakes:
  - in_ready = !pend_v (registered-state function; no combinational path from out_ready).
  - Input accept = in_valid && in_ready. Output beat = out_valid && out_ready.
- Transitions:
  - IDLE + accept: load SHIFT=data_in, CNT=NUM_SHIFTS, go to SHIFT. First slice is valid the cycle after acceptance (latency 1).
  - SHIFT + beat with CNT>1: SHIFT >>= DATA_OUT_WIDTH, CNT-=1.
  - SHIFT + beat with CNT==1 (last slice):
    - If pend_v: load SHIFT from PEND, clear pend_v, CNT=NUM_SHIFTS.
    - Else if accept this cycle: load SHIFT from data_in directly.
    - Else: go to IDLE.
    - No bubble between consecutive words.
  - SHIFT + accept, not consuming the last slice: data_in goes to PEND, pend_v=1.
  - Last beat and accept in the same cycle while pend_v=1: not possible, because in_ready=0.
- Stall: while out_valid && !out_ready, data_out, CNT and SHIFT hold. Accept into PEND is still allowed if it is empty.
- DATA_IN_WIDTH==DATA_OUT_WIDTH: NUM_SHIFTS=1, block acts as a 2-deep skid buffer; no shifting.
- busy = (state==SHIFT) || pend_v.
- Sustained throughput: one slice per cycle with out_ready tied high and in_valid kept asserted.

Optional Feature:
- Macro PISO_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit), asserted with out_valid on the final slice of each word (CNT==1); reset value 0.
  - Adds input port in_flush (1 bit): when sampled high, discards SHIFT and PEND, returns to IDLE next cycle, and out_last is not emitted for the discarded word.
- Undefined: neither port exists and the logic is removed; all other behaviour is identical.

Test Plan:
- Single word, 64->16, out_ready=1: accept 0x4444_3333_2222_1111 at cycle 0 -> data_out 0x1111, 0x2222, 0x3333, 0x4444 on cycles 1-4 with out_valid=1; out_valid=0 at cycle 5; busy=0 from cycle 5.
- Back-to-back: in_valid held with words A then B, out_ready=1 -> 8 consecutive valid slices with no gap; in_ready drops while B is pending and rises again when B moves to SHIFT.
- Backpressure: out_ready=0 for 3 cycles after slice 2 -> data_out holds 0x2222 for 4 cycles, then resumes with 0x3333; no slice lost or duplicated.
- Reset mid-word: reset pulled low after slice 0x2222 -> out_valid=0 and busy=0 asynchronously; after release, a new word 0xDDDD_CCCC_BBBB_AAAA emits 0xAAAA first.
- Equal widths, 16->16: stream 0x0001..0x0005 with random out_ready -> output sequence matches exactly; in_ready=0 only when PEND is full.
- Loopback: piso(64->16) feeding sipo(16->64), 100 random words -> sipo output matches piso input in order; with PISO_LAST_EN, out_last is high on every 4th beat only.
